// File: rtl/sha256_sched_arbiter.sv
// Round-robin arbiter that shares one SHA-256 message-schedule extender
// between NREQ hash cores. It issues one chunk at a time and holds the grant
// until the granted core accepts its 64-word schedule.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_vld/rdy     per-core chunk handshake
//   req_data        NREQ packed chunks of 16 x 32 bits, word 0 in the low bits
//   ext_chunk_*     chunk handshake toward the extender
//   ext_w_*         schedule handshake from the extender (64 x 32 bits)
//   res_vld/rdy     per-core schedule handshake
//   res_w           shared schedule bus, valid only while res_vld is high
//   res_id          id of the current or most recent grant
//   busy            arbiter is not idle
//   done_cnt        schedules delivered, wraps
//   err             sticky: extender schedule valid seen outside WAIT
module sha256_sched_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_vld,
    output logic [NREQ-1:0]          req_rdy,
    input  logic [NREQ*16*32-1:0]    req_data,
    output logic                     ext_chunk_vld,
    input  logic                     ext_chunk_rdy,
    output logic [16*32-1:0]         ext_chunk_data,
    input  logic                     ext_w_vld,
    output logic                     ext_w_rdy,
    input  logic [64*32-1:0]         ext_w,
    output logic [NREQ-1:0]          res_vld,
    input  logic [NREQ-1:0]          res_rdy,
    output logic [64*32-1:0]         res_w,
    output logic [IDW-1:0]           res_id,
    output logic                     busy,
    output logic [31:0]              done_cnt,
    output logic                     err
);

    localparam int unsigned CW = 16 * 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  winner;
    logic            found;
    logic            grant_ld;
    logic            deliver;
    logic [CW-1:0]   chunk_arr [NREQ];

    // Unpacked view of the requester chunks so the grant id can index directly
    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign chunk_arr[g] = req_data[g*CW +: CW];
    end

    // First requesting index at or after ptr, wrapping around
    always_comb begin
        logic [IDW-1:0] idx;
        int unsigned    k;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        k      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k   = (32'(ptr) + i) % NREQ;
            idx = IDW'(k);
            if (!found && req_vld[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake steering; only the granted lane ever sees a handshake
    always_comb begin
        state_d       = state_q;
        req_rdy       = '0;
        res_vld       = '0;
        ext_chunk_vld = 1'b0;
        ext_w_rdy     = 1'b0;
        grant_ld      = 1'b0;
        deliver       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_ld = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ext_chunk_vld   = req_vld[res_id];
                req_rdy[res_id] = ext_chunk_rdy;
                if (req_vld[res_id] && ext_chunk_rdy) begin
                    state_d = ST_WAIT;
                end else if (!req_vld[res_id]) begin
                    // requester withdrew before the extender took the chunk
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                res_vld[res_id] = ext_w_vld;
                ext_w_rdy       = res_rdy[res_id];
                if (ext_w_vld && res_rdy[res_id]) begin
                    deliver = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant id, fairness pointer, delivery count and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_id   <= '0;
            ptr      <= '0;
            done_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (grant_ld) begin
                res_id <= winner;
            end
            if (deliver) begin
                ptr      <= (res_id == IDW'(NREQ - 1)) ? '0 : res_id + IDW'(1);
                done_cnt <= done_cnt + 32'd1;
            end
            if (ext_w_vld && (state_q != ST_WAIT)) begin
                err <= 1'b1;
            end
        end
    end

    assign ext_chunk_data = chunk_arr[res_id];
    assign res_w          = ext_w;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_sched_arbiter.sv
// Directed bench for sha256_sched_arbiter with a behavioural extender model.
module tb_sha256_sched_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 10;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_vld;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*512-1:0]   req_data;
    logic                  ext_chunk_vld;
    logic                  ext_chunk_rdy;
    logic [511:0]          ext_chunk_data;
    logic                  ext_w_vld;
    logic                  ext_w_rdy;
    logic [2047:0]         ext_w;
    logic [NREQ-1:0]       res_vld;
    logic [NREQ-1:0]       res_rdy;
    logic [2047:0]         res_w;
    logic [IDW-1:0]        res_id;
    logic                  busy;
    logic [31:0]           done_cnt;
    logic                  err;

    int total = 0;
    int bad   = 0;

    sha256_sched_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data),
        .ext_chunk_vld(ext_chunk_vld), .ext_chunk_rdy(ext_chunk_rdy),
        .ext_chunk_data(ext_chunk_data),
        .ext_w_vld(ext_w_vld), .ext_w_rdy(ext_w_rdy), .ext_w(ext_w),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_w(res_w),
        .res_id(res_id), .busy(busy), .done_cnt(done_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 message schedule expansion
    function automatic logic [2047:0] sched(input logic [511:0] c);
        logic [31:0]   w [64];
        logic [31:0]   s0;
        logic [31:0]   s1;
        logic [2047:0] r;
        for (int t = 0; t < 16; t++) w[t] = c[t*32 +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t];
        return r;
    endfunction

    function automatic logic [511:0] mk_chunk(input int id);
        logic [511:0] c;
        for (int j = 0; j < 16; j++)
            c[j*32 +: 32] = {8'(id + 1), 8'(j), 16'hA5C3 ^ 16'(j * 7 + id * 3)};
        return c;
    endfunction

    function automatic logic [511:0] abc_chunk();
        logic [511:0] c;
        c = '0;
        c[31:0]    = 32'h61626380;
        c[511:480] = 32'h00000018;
        return c;
    endfunction

    task automatic set_chunk(input int i, input logic [511:0] c);
        req_data[i*512 +: 512] = c;
    endtask

    // Behavioural extender: one chunk in flight, fixed latency, holds schedule until taken
    logic          mdl_busy;
    logic          mdl_vld;
    int            mdl_cnt;
    logic [2047:0] mdl_w;
    logic          chunk_rdy_en;
    logic          force_w_vld;

    assign ext_chunk_rdy = !mdl_busy && chunk_rdy_en;
    assign ext_w_vld     = mdl_vld | force_w_vld;
    assign ext_w         = mdl_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy <= 1'b0;
            mdl_vld  <= 1'b0;
            mdl_cnt  <= 0;
            mdl_w    <= '0;
        end else begin
            if (ext_chunk_vld && ext_chunk_rdy) begin
                mdl_busy <= 1'b1;
                mdl_w    <= sched(ext_chunk_data);
                mdl_cnt  <= LAT;
            end else if (mdl_busy && !mdl_vld) begin
                if (mdl_cnt == 0) mdl_vld <= 1'b1;
                else mdl_cnt <= mdl_cnt - 1;
            end
            if (mdl_vld && ext_w_rdy) begin
                mdl_vld  <= 1'b0;
                mdl_busy <= 1'b0;
            end
        end
    end

    // Delivery log, overlap and chunk-handshake counters
    int            q_id [$];
    logic [2047:0] q_w  [$];
    int            overlap  = 0;
    int            chunk_hs = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++)
                if (res_vld[i] && res_rdy[i]) begin
                    q_id.push_back(i);
                    q_w.push_back(res_w);
                end
            if ($countones(res_vld) > 1) overlap++;
            if (ext_chunk_vld && ext_chunk_rdy) chunk_hs++;
        end
    end

    task automatic wait_deliv(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (q_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '0; res_rdy = '0; req_data = '0;
        chunk_rdy_en = 1'b1; force_w_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (res_vld !== 4'b0) begin bad++; $display("FAIL rst_res_vld got=%b exp=0000", res_vld); end
        total++; if (req_rdy !== 4'b0) begin bad++; $display("FAIL rst_req_rdy got=%b exp=0000", req_rdy); end
        total++; if ({ext_chunk_vld, ext_w_rdy} !== 2'b00) begin bad++; $display("FAIL rst_ext got=%b%b exp=00", ext_chunk_vld, ext_w_rdy); end
        total++; if (done_cnt !== 32'd0) begin bad++; $display("FAIL rst_done got=%0d exp=0", done_cnt); end
        total++; if ({err, res_id} !== 3'b000) begin bad++; $display("FAIL rst_err_id got=%b/%0d exp=0/0", err, res_id); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        bit ok;
        bit seen;
        q_id.delete(); q_w.delete();
        for (int i = 0; i < NREQ; i++) set_chunk(i, mk_chunk(i));
        set_chunk(2, abc_chunk());
        res_rdy = 4'hF;
        req_vld = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = res_vld[2];
        end
        total++; if (!seen) begin bad++; $display("FAIL abc_res_vld timeout got=%b exp=0100", res_vld); end
        total++; if (res_id !== 2'd2) begin bad++; $display("FAIL abc_res_id got=%0d exp=2", res_id); end
        total++; if (res_w[16*32 +: 32] !== 32'h61626380) begin bad++; $display("FAIL abc_w16 got=%h exp=61626380", res_w[16*32 +: 32]); end
        total++; if (res_w[17*32 +: 32] !== 32'h000F0000) begin bad++; $display("FAIL abc_w17 got=%h exp=000f0000", res_w[17*32 +: 32]); end
        total++; if (ext_w_rdy !== 1'b1) begin bad++; $display("FAIL abc_ext_w_rdy got=%b exp=1", ext_w_rdy); end
        req_vld = '0;
        @(negedge clk);
        total++; if (done_cnt !== 32'd1) begin bad++; $display("FAIL abc_done got=%0d exp=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abc_idle busy=%b exp=0", busy); end
        // ptr is now 3: req 3 must beat req 0
        set_chunk(3, mk_chunk(3));
        req_vld = 4'b1001;
        wait_deliv(2, ok);
        req_vld = '0;
        total++; if (!ok) begin bad++; $display("FAIL abc_ptr timeout got=%0d exp=2 deliveries", q_id.size()); end
        if (ok) begin
            total++; if (q_id[1] != 3) begin bad++; $display("FAIL abc_ptr_grant got=%0d exp=3", q_id[1]); end
            total++; if (q_w[1] !== sched(mk_chunk(3))) begin bad++; $display("FAIL abc_ptr_data w16 got=%h exp=%h", q_w[1][16*32 +: 32], sched(mk_chunk(3)) >> (16*32)); end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [2047:0] exp_w;
        do_reset();
        q_id.delete(); q_w.delete(); overlap = 0;
        for (int i = 0; i < NREQ; i++) set_chunk(i, mk_chunk(i));
        res_rdy = 4'hF;
        req_vld = 4'hF;
        wait_deliv(5, ok);
        req_vld = '0;
        total++; if (!ok) begin bad++; $display("FAIL rr timeout got=%0d exp=5 deliveries", q_id.size()); end
        if (ok) begin
            for (int k = 0; k < 5; k++) begin
                exp_w = sched(mk_chunk(k % 4));
                total++; if (q_id[k] != k % 4) begin bad++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, q_id[k], k % 4); end
                total++; if (q_w[k] !== exp_w) begin bad++; $display("FAIL rr_data k=%0d w63 got=%h exp=%h", k, q_w[k][63*32 +: 32], exp_w[63*32 +: 32]); end
            end
        end
        total++; if (overlap != 0) begin bad++; $display("FAIL rr_overlap got=%0d exp=0", overlap); end
        total++; if (done_cnt !== 32'd5) begin bad++; $display("FAIL rr_done got=%0d exp=5", done_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        int hs0;
        q_id.delete(); q_w.delete();
        res_rdy = 4'b1101;
        req_vld = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = res_vld[1];
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_res_vld timeout got=%b exp=0010", res_vld); end
        req_vld = 4'b0001;
        hs0 = chunk_hs;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++; if ({res_vld, ext_w_rdy} !== 5'b0010_0) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%b exp=0010/0", c, res_vld, ext_w_rdy); end
        end
        total++; if (chunk_hs != hs0 || q_id.size() != 0) begin bad++; $display("FAIL bp_no_grant hs=%0d deliv=%0d exp=%0d/0", chunk_hs, q_id.size(), hs0); end
        res_rdy = 4'hF;
        wait_deliv(2, ok);
        req_vld = '0;
        total++; if (!ok) begin bad++; $display("FAIL bp timeout got=%0d exp=2 deliveries", q_id.size()); end
        if (ok) begin
            total++; if (q_id[0] != 1 || q_id[1] != 0) begin bad++; $display("FAIL bp_order got=%0d,%0d exp=1,0", q_id[0], q_id[1]); end
        end
        total++; if (done_cnt !== 32'd7) begin bad++; $display("FAIL bp_done got=%0d exp=7", done_cnt); end
    endtask

    task automatic test_withdraw();
        bit ok;
        bit seen;
        int hs0;
        q_id.delete(); q_w.delete();
        chunk_rdy_en = 1'b0;
        req_vld = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = busy;
        end
        total++; if (!seen || res_id !== 2'd3) begin bad++; $display("FAIL wd_grant busy=%b id=%0d exp=1/3", busy, res_id); end
        total++; if ({ext_chunk_vld, req_rdy} !== 5'b1_0000) begin bad++; $display("FAIL wd_issue got=%b/%b exp=1/0000", ext_chunk_vld, req_rdy); end
        hs0 = chunk_hs;
        req_vld = '0;
        @(negedge clk);
        total++; if ({busy, ext_chunk_vld} !== 2'b00) begin bad++; $display("FAIL wd_idle got=%b%b exp=00", busy, ext_chunk_vld); end
        total++; if (chunk_hs != hs0) begin bad++; $display("FAIL wd_no_hs got=%0d exp=%0d", chunk_hs, hs0); end
        chunk_rdy_en = 1'b1;
        req_vld = 4'b1001;
        wait_deliv(1, ok);
        req_vld = '0;
        total++; if (!ok) begin bad++; $display("FAIL wd timeout got=%0d exp=1 delivery", q_id.size()); end
        if (ok) begin
            total++; if (q_id[0] != 3) begin bad++; $display("FAIL wd_regrant got=%0d exp=3", q_id[0]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        q_id.delete(); q_w.delete();
        res_rdy = '0;
        req_vld = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = res_vld[0];
        end
        req_vld = '0;
        total++; if (!seen || busy !== 1'b1) begin bad++; $display("FAIL rmw_wait res_vld=%b busy=%b exp=0001/1", res_vld, busy); end
        rst_n = 1'b0;
        #1;
        total++; if ({busy, res_vld, ext_w_rdy} !== 6'b0) begin bad++; $display("FAIL rmw_async got=%b/%b/%b exp=0/0000/0", busy, res_vld, ext_w_rdy); end
        total++; if (done_cnt !== 32'd0) begin bad++; $display("FAIL rmw_done got=%0d exp=0", done_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        res_rdy = 4'hF;
        @(negedge clk);
        @(negedge clk);
        total++; if ({busy, res_vld} !== 5'b0 || done_cnt !== 32'd0) begin bad++; $display("FAIL rmw_after busy=%b res_vld=%b done=%0d exp=0/0000/0", busy, res_vld, done_cnt); end
        total++; if (q_id.size() != 0) begin bad++; $display("FAIL rmw_partial got=%0d exp=0 deliveries", q_id.size()); end
    endtask

    task automatic test_err();
        bit ok;
        q_id.delete(); q_w.delete();
        res_rdy = 4'hF;
        force_w_vld = 1'b1;
        @(negedge clk);
        force_w_vld = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
        total++; if (ext_w_rdy !== 1'b0) begin bad++; $display("FAIL err_ext_w_rdy got=%b exp=0", ext_w_rdy); end
        set_chunk(2, abc_chunk());
        req_vld = 4'b0100;
        wait_deliv(1, ok);
        req_vld = '0;
        total++; if (!ok) begin bad++; $display("FAIL err_txn timeout got=%0d exp=1 delivery", q_id.size()); end
        if (ok) begin
            total++; if (q_id[0] != 2 || q_w[0] !== sched(abc_chunk())) begin bad++; $display("FAIL err_txn id=%0d w17=%h exp=2/000f0000", q_id[0], q_w[0][17*32 +: 32]); end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_reset_mid_wait();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
